// File: rtl/chimera_clu_iso_ctrl_pkg.sv
// Shared types and constants for the per-cluster isolation sequencer.
// Imported by the FSM, the top and the interface users.
package chimera_clu_iso_ctrl_pkg;

  typedef enum logic [2:0] {
    ACTIVE   = 3'd0,
    DRAIN    = 3'd1,
    TIMEOUT  = 3'd2,
    ISOLATED = 3'd3,
    WAKE     = 3'd4,
    RELEASE  = 3'd5
  } iso_state_e;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_ACTIVE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_TIMEOUT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISOLATED = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAKE     = 3'd4;
  localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd5;

  // One counter serves both the drain timeout and the wake settle time.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/chimera_clu_iso_ctrl_if.sv
// Signal bundle between the cluster-domain controller and its environment.
// state_dbg_o carries each cluster's FSM state, STATE_W bits per cluster.
interface chimera_clu_iso_ctrl_if #(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned NumPorts    = 4
);
  import chimera_clu_iso_ctrl_pkg::*;

  logic [NumClusters-1:0]          iso_req_i;
  logic [NumClusters*NumPorts-1:0] port_isolated_i;
  logic [NumClusters-1:0]          timeout_clr_i;
  logic [NumClusters*NumPorts-1:0] port_isolate_o;
  logic [NumClusters-1:0]          clk_en_o;
  logic [NumClusters-1:0]          clu_rst_no;
  logic [NumClusters-1:0]          isolated_o;
  logic [NumClusters-1:0]          busy_o;
  logic [NumClusters-1:0]          timeout_o;
  logic [NumClusters*STATE_W-1:0]  state_dbg_o;

  modport master (
    output iso_req_i, port_isolated_i, timeout_clr_i,
    input  port_isolate_o, clk_en_o, clu_rst_no, isolated_o, busy_o, timeout_o, state_dbg_o
  );

  modport slave (
    input  iso_req_i, port_isolated_i, timeout_clr_i,
    output port_isolate_o, clk_en_o, clu_rst_no, isolated_o, busy_o, timeout_o, state_dbg_o
  );

endinterface

// File: rtl/chimera_clu_iso_fsm.sv
// Isolation sequencer for a single cluster: drain the AXI ports, gate the clock,
// hold reset; wake runs the reverse with a settle period. Outputs are Moore.
module chimera_clu_iso_fsm
  import chimera_clu_iso_ctrl_pkg::*;
#(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter int unsigned SettleCycles   = 16,
  parameter bit          ForceOnTimeout = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iso_req,
  input  logic [NumPorts-1:0] port_isolated,
  input  logic                timeout_clr,
  output logic [NumPorts-1:0] port_isolate,
  output logic                clk_en,
  output logic                clu_rst_n,
  output logic                isolated,
  output logic                busy,
  output logic                timeout,
  output logic [STATE_W-1:0]  state_dbg
);

  localparam int unsigned     CntW        = cnt_width(TimeoutCycles, SettleCycles);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCycles - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               timeout_q;
  logic               timeout_set;
  logic               all_isolated;

  assign all_isolated = &port_isolated;

  always_comb begin
    state_d     = ST_ACTIVE;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (iso_req) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      // Drained ports win over an abort or a timeout in the same cycle.
      ST_DRAIN: begin
        if (all_isolated) begin
          state_d = ST_ISOLATED;
        end else if (!iso_req) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == TimeoutLast) begin
          timeout_set = 1'b1;
          state_d     = ForceOnTimeout ? ST_ISOLATED : ST_TIMEOUT;
        end else begin
          state_d = ST_DRAIN;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      ST_TIMEOUT: begin
        if (all_isolated) begin
          state_d = ST_ISOLATED;
        end else if (!iso_req) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_ISOLATED: begin
        if (!iso_req) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end else begin
          state_d = ST_ISOLATED;
        end
      end
      // Wake cannot be aborted: the cluster must come fully out of reset first.
      ST_WAKE: begin
        if (cnt_q == SettleLast) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_WAKE;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      ST_RELEASE: state_d = ST_ACTIVE;
      default:    state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACTIVE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr) begin
        timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    port_isolate = '0;
    clk_en       = 1'b1;
    clu_rst_n    = 1'b1;
    isolated     = 1'b0;
    busy         = 1'b0;
    case (state_q)
      ST_DRAIN, ST_TIMEOUT: begin
        port_isolate = '1;
        busy         = 1'b1;
      end
      ST_ISOLATED: begin
        port_isolate = '1;
        clk_en       = 1'b0;
        clu_rst_n    = 1'b0;
        isolated     = 1'b1;
      end
      ST_WAKE: begin
        port_isolate = '1;
        clu_rst_n    = 1'b0;
        busy         = 1'b1;
      end
      // Reset is already released here; ports open one cycle later.
      ST_RELEASE: begin
        port_isolate = '1;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/chimera_clu_iso_ctrl.sv
// Cluster-domain isolation controller: one independent sequencer per cluster,
// the top only slices the shared vectors.
module chimera_clu_iso_ctrl
  import chimera_clu_iso_ctrl_pkg::*;
#(
  parameter int unsigned NumClusters    = 5,
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter int unsigned SettleCycles   = 16,
  parameter bit          ForceOnTimeout = 1'b0
) (
  input logic                   soc_clk_i,
  input logic                   rst_ni,
  chimera_clu_iso_ctrl_if.slave bus
);

  for (genvar c = 0; c < NumClusters; c++) begin : g_clu
    chimera_clu_iso_fsm #(
      .NumPorts       (NumPorts),
      .TimeoutCycles  (TimeoutCycles),
      .SettleCycles   (SettleCycles),
      .ForceOnTimeout (ForceOnTimeout)
    ) u_fsm (
      .clk           (soc_clk_i),
      .rst_n         (rst_ni),
      .iso_req       (bus.iso_req_i[c]),
      .port_isolated (bus.port_isolated_i[c*NumPorts +: NumPorts]),
      .timeout_clr   (bus.timeout_clr_i[c]),
      .port_isolate  (bus.port_isolate_o[c*NumPorts +: NumPorts]),
      .clk_en        (bus.clk_en_o[c]),
      .clu_rst_n     (bus.clu_rst_no[c]),
      .isolated      (bus.isolated_o[c]),
      .busy          (bus.busy_o[c]),
      .timeout       (bus.timeout_o[c]),
      .state_dbg     (bus.state_dbg_o[c*STATE_W +: STATE_W])
    );
  end

endmodule

// File: tb/tb_chimera_clu_iso_ctrl.sv
// Bench for chimera_clu_iso_ctrl: a waiting instance (a) and a forced-timeout
// instance (b), directed vectors plus random traffic against a phase model.
module tb_chimera_clu_iso_ctrl;

  localparam int NC = 5;
  localparam int NP = 4;
  localparam int TO = 8;
  localparam int ST = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chimera_clu_iso_ctrl_if #(.NumClusters(NC), .NumPorts(NP)) if_a ();
  chimera_clu_iso_ctrl_if #(.NumClusters(NC), .NumPorts(NP)) if_b ();

  chimera_clu_iso_ctrl #(
    .NumClusters(NC), .NumPorts(NP), .TimeoutCycles(TO), .SettleCycles(ST), .ForceOnTimeout(1'b0)
  ) u_dut_a (.soc_clk_i(clk), .rst_ni(rst_n), .bus(if_a));

  chimera_clu_iso_ctrl #(
    .NumClusters(NC), .NumPorts(NP), .TimeoutCycles(TO), .SettleCycles(ST), .ForceOnTimeout(1'b1)
  ) u_dut_b (.soc_clk_i(clk), .rst_ni(rst_n), .bus(if_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each cluster is in a phase; timing is measured as the
  // distance between the current cycle number and the phase start cycle.
  typedef enum int {P_ACT, P_DRAIN, P_STUCK, P_ISO, P_WAKE, P_REL} phase_t;
  phase_t m_ph[2][NC];
  int     m_t0[2][NC];
  bit     m_to[2][NC];
  int     cyc    = 0;
  bit     chk_on = 1'b0;

  always @(posedge clk) begin
    logic [NC-1:0]    req[2];
    logic [NC*NP-1:0] prt[2];
    logic [NC-1:0]    clr[2];
    bit full;
    bit set_to;
    req[0] = if_a.iso_req_i; prt[0] = if_a.port_isolated_i; clr[0] = if_a.timeout_clr_i;
    req[1] = if_b.iso_req_i; prt[1] = if_b.port_isolated_i; clr[1] = if_b.timeout_clr_i;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) begin
        full   = &prt[k][c*NP +: NP];
        set_to = 1'b0;
        if (!rst_n) begin
          m_ph[k][c] = P_ACT;
          m_to[k][c] = 1'b0;
        end else begin
          case (m_ph[k][c])
            P_ACT:   if (req[k][c]) begin m_ph[k][c] = P_DRAIN; m_t0[k][c] = cyc + 1; end
            P_DRAIN: begin
              if (full) m_ph[k][c] = P_ISO;
              else if (!req[k][c]) m_ph[k][c] = P_ACT;
              else if (cyc - m_t0[k][c] == TO - 1) begin
                set_to = 1'b1;
                m_ph[k][c] = (k == 1) ? P_ISO : P_STUCK;
              end
            end
            P_STUCK: begin
              if (full) m_ph[k][c] = P_ISO;
              else if (!req[k][c]) m_ph[k][c] = P_ACT;
            end
            P_ISO:   if (!req[k][c]) begin m_ph[k][c] = P_WAKE; m_t0[k][c] = cyc + 1; end
            P_WAKE:  if (cyc - m_t0[k][c] == ST - 1) m_ph[k][c] = P_REL;
            P_REL:   m_ph[k][c] = P_ACT;
            default: m_ph[k][c] = P_ACT;
          endcase
          if (set_to) m_to[k][c] = 1'b1;
          else if (clr[k][c]) m_to[k][c] = 1'b0;
        end
      end
    end
    cyc++;
  end

  // scoreboard: every cycle, both instances against the model
  always @(posedge clk) begin
    logic [NC*NP-1:0] e_pi;
    logic [NC-1:0]    e_ce, e_rn, e_iso, e_busy, e_to;
    #1;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < NC; c++) begin
          e_pi[c*NP +: NP] = (m_ph[k][c] == P_ACT) ? 4'h0 : 4'hF;
          e_ce[c]   = (m_ph[k][c] != P_ISO);
          e_rn[c]   = (m_ph[k][c] != P_ISO) && (m_ph[k][c] != P_WAKE);
          e_iso[c]  = (m_ph[k][c] == P_ISO);
          e_busy[c] = (m_ph[k][c] == P_DRAIN) || (m_ph[k][c] == P_STUCK) ||
                      (m_ph[k][c] == P_WAKE)  || (m_ph[k][c] == P_REL);
          e_to[c]   = m_to[k][c];
        end
        check($sformatf("model%0d_port_isolate", k), (k == 0) ? if_a.port_isolate_o : if_b.port_isolate_o, e_pi);
        check($sformatf("model%0d_clk_en", k),       (k == 0) ? if_a.clk_en_o   : if_b.clk_en_o,   e_ce);
        check($sformatf("model%0d_clu_rst_n", k),    (k == 0) ? if_a.clu_rst_no : if_b.clu_rst_no, e_rn);
        check($sformatf("model%0d_isolated", k),     (k == 0) ? if_a.isolated_o : if_b.isolated_o, e_iso);
        check($sformatf("model%0d_busy", k),         (k == 0) ? if_a.busy_o     : if_b.busy_o,     e_busy);
        check($sformatf("model%0d_timeout", k),      (k == 0) ? if_a.timeout_o  : if_b.timeout_o,  e_to);
      end
    end
  end

  // directed vectors for cluster 0 of instance a
  typedef struct {
    int         n;
    logic       req;
    logic [3:0] prt;
    logic       clr;
    logic [3:0] e_pi;
    logic [4:0] e_st;   // {clk_en, clu_rst_n, isolated, busy, timeout}
  } vec_t;
  vec_t vt[$];

  task automatic add(input int n, input logic req, input logic [3:0] prt, input logic clr,
                     input logic [3:0] e_pi, input logic [4:0] e_st);
    vec_t v;
    v.n = n; v.req = req; v.prt = prt; v.clr = clr; v.e_pi = e_pi; v.e_st = e_st;
    vt.push_back(v);
  endtask

  initial begin
    logic [NC-1:0]    r_v[2];
    logic [NC*NP-1:0] p_v[2];
    logic [NC-1:0]    c_v[2];

    add( 1, 1'b0, 4'h0, 1'b0, 4'h0, 5'b11000);  // idle ACTIVE
    add( 1, 1'b1, 4'h0, 1'b0, 4'hF, 5'b11010);  // DRAIN entry
    add( 4, 1'b1, 4'h0, 1'b0, 4'hF, 5'b11010);
    add( 1, 1'b1, 4'hF, 1'b0, 4'hF, 5'b00100);  // drained -> ISOLATED
    add( 3, 1'b1, 4'h0, 1'b0, 4'hF, 5'b00100);  // port drop ignored
    add( 1, 1'b0, 4'h0, 1'b0, 4'hF, 5'b10010);  // WAKE
    add(15, 1'b0, 4'h0, 1'b0, 4'hF, 5'b10010);  // last settle cycle
    add( 1, 1'b1, 4'h0, 1'b0, 4'hF, 5'b11010);  // RELEASE, req ignored
    add( 1, 1'b1, 4'h0, 1'b0, 4'h0, 5'b11000);  // ACTIVE
    add( 1, 1'b1, 4'h7, 1'b0, 4'hF, 5'b11010);  // DRAIN again
    add( 7, 1'b1, 4'h7, 1'b0, 4'hF, 5'b11010);  // one short of timeout
    add( 1, 1'b1, 4'h7, 1'b1, 4'hF, 5'b11011);  // set beats clear
    add( 3, 1'b1, 4'h7, 1'b0, 4'hF, 5'b11011);  // TIMEOUT holds
    add( 1, 1'b1, 4'hF, 1'b0, 4'hF, 5'b00101);  // late drain -> ISOLATED
    add( 1, 1'b1, 4'hF, 1'b1, 4'hF, 5'b00100);  // clear flag
    add(18, 1'b0, 4'h0, 1'b0, 4'h0, 5'b11000);  // full wake back to ACTIVE
    add( 3, 1'b1, 4'h0, 1'b0, 4'hF, 5'b11010);
    add( 1, 1'b0, 4'h0, 1'b0, 4'h0, 5'b11000);  // abort
    add( 9, 1'b1, 4'h0, 1'b0, 4'hF, 5'b11011);  // timeout again
    add( 1, 1'b0, 4'h0, 1'b0, 4'h0, 5'b11001);  // abort from TIMEOUT, flag held
    add( 1, 1'b0, 4'h0, 1'b1, 4'h0, 5'b11000);

    if_a.iso_req_i = '0; if_a.port_isolated_i = '0; if_a.timeout_clr_i = '0;
    if_b.iso_req_i = '0; if_b.port_isolated_i = '0; if_b.timeout_clr_i = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_clk_en",  if_a.clk_en_o,       {NC{1'b1}});
    check("reset_rst_n",   if_a.clu_rst_no,     {NC{1'b1}});
    check("reset_ports",   if_a.port_isolate_o, '0);
    check("reset_status",  {if_a.isolated_o, if_a.busy_o, if_a.timeout_o}, '0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    foreach (vt[i]) begin
      for (int j = 0; j < vt[i].n; j++) begin
        if_a.iso_req_i[0]           = vt[i].req;
        if_a.port_isolated_i[NP-1:0] = vt[i].prt;
        if_a.timeout_clr_i[0]       = vt[i].clr;
        tick();
      end
      check($sformatf("vec%0d_ports", i), if_a.port_isolate_o[NP-1:0], vt[i].e_pi);
      check($sformatf("vec%0d_status", i),
            {if_a.clk_en_o[0], if_a.clu_rst_no[0], if_a.isolated_o[0], if_a.busy_o[0], if_a.timeout_o[0]},
            vt[i].e_st);
    end
    if_a.iso_req_i = '0; if_a.port_isolated_i = '0; if_a.timeout_clr_i = '0;
    tick();

    // forced isolation: exactly TO cycles after DRAIN entry
    if_b.iso_req_i[0] = 1'b1;
    tick();
    repeat (TO - 1) tick();
    check("force_before", {if_b.clk_en_o[0], if_b.isolated_o[0], if_b.timeout_o[0]}, 3'b100);
    tick();
    check("force_isolated", {if_b.clk_en_o[0], if_b.isolated_o[0], if_b.timeout_o[0]}, 3'b011);
    if_b.iso_req_i[0] = 1'b0;
    repeat (ST + 2) tick();
    check("force_woken", {if_b.port_isolate_o[NP-1:0], if_b.clk_en_o[0], if_b.timeout_o[0]}, 6'b000011);
    if_b.timeout_clr_i[0] = 1'b1;
    tick();
    if_b.timeout_clr_i[0] = 1'b0;
    check("force_clr", if_b.timeout_o[0], 1'b0);

    // independence: cluster 1 wakes while cluster 2 isolates
    if_a.iso_req_i[1] = 1'b1;
    if_a.port_isolated_i[7:4] = 4'hF;
    repeat (2) tick();
    check("indep_c1_iso", if_a.isolated_o, 5'b00010);
    if_a.iso_req_i[1] = 1'b0;
    if_a.iso_req_i[2] = 1'b1;
    if_a.port_isolated_i[7:4] = 4'h0;
    repeat (3) tick();
    if_a.port_isolated_i[11:8] = 4'hF;
    tick();
    check("indep_isolated", if_a.isolated_o,     5'b00100);
    check("indep_clk_en",   if_a.clk_en_o,       5'b11011);
    check("indep_rst_n",    if_a.clu_rst_no,     5'b11001);
    check("indep_busy",     if_a.busy_o,         5'b00010);
    check("indep_ports",    if_a.port_isolate_o, 20'h00FF0);
    if_a.iso_req_i[2] = 1'b0;
    if_a.port_isolated_i = '0;
    repeat (ST + 4) tick();

    // reset in the middle of WAKE, with a timeout flag pending
    if_a.iso_req_i[3] = 1'b1;
    repeat (TO + 1) tick();
    check("rst_seq_timeout", if_a.timeout_o[3], 1'b1);
    if_a.port_isolated_i[15:12] = 4'hF;
    tick();
    if_a.iso_req_i[3] = 1'b0;
    if_a.port_isolated_i = '0;
    repeat (3) tick();
    check("rst_seq_in_wake", {if_a.clk_en_o[3], if_a.clu_rst_no[3], if_a.busy_o[3]}, 3'b101);
    rst_n = 1'b0;
    tick();
    check("rst_mid_clk_en",  if_a.clk_en_o,       {NC{1'b1}});
    check("rst_mid_rst_n",   if_a.clu_rst_no,     {NC{1'b1}});
    check("rst_mid_ports",   if_a.port_isolate_o, '0);
    check("rst_mid_status",  {if_a.busy_o, if_a.timeout_o, if_a.isolated_o}, '0);
    check("rst_mid_state",   if_a.state_dbg_o,    '0);
    rst_n = 1'b1;
    tick();

    // random traffic on both instances, checked by the model scoreboard
    r_v[0] = '0; r_v[1] = '0;
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < NC; c++) begin
          if ($urandom_range(0, 15) == 0) r_v[k][c] = ~r_v[k][c];
          p_v[k][c*NP +: NP] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
          c_v[k][c] = ($urandom_range(0, 7) == 0);
        end
      end
      if_a.iso_req_i = r_v[0]; if_a.port_isolated_i = p_v[0]; if_a.timeout_clr_i = c_v[0];
      if_b.iso_req_i = r_v[1]; if_b.port_isolated_i = p_v[1]; if_b.timeout_clr_i = c_v[1];
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    if_a.iso_req_i = '0; if_a.port_isolated_i = '0; if_a.timeout_clr_i = '0;
    if_b.iso_req_i = '0; if_b.port_isolated_i = '0; if_b.timeout_clr_i = '0;
    rst_n = 1'b1;
    repeat (ST + 4) tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
